// File: rtl/restador_serial.sv
// Serial subtractor: D = A - B - Bin, Chunk bits per clock, LSB first.
// Optional Zero flag output when RESTADOR_ZERO_FLAG_EN is defined.
module restador_serial #(
  parameter int Ancho = 8,
  parameter int Chunk = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Ancho-1:0] A,
  input  logic [Ancho-1:0] B,
  input  logic             Bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Ancho-1:0] D,
  output logic             Bout,
  output logic             Overflow,
  output logic             out_valid,
`ifdef RESTADOR_ZERO_FLAG_EN
  output logic             Zero,
`endif
  input  logic             out_ready
);

  localparam int K  = Ancho / Chunk;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  generate
    if ((Ancho % Chunk) != 0 || Chunk < 1) begin : g_bad_params
      $error("restador_serial: Ancho must be a positive multiple of Chunk");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [Ancho-1:0] a_sh, b_sh, d_reg;
  logic [CW-1:0]    cnt;
  logic             borrow, bout_q, ovf_q;
  logic             accept, last_chunk;
  logic [Chunk:0]   chunk_full;
  logic [Chunk-1:0] chunk_d;
  logic             chunk_bout, chunk_ovf;

  // Operands shift right so the current chunk is always the low Chunk bits.
  always_comb begin
    chunk_full = {1'b0, a_sh[Chunk-1:0]} - {1'b0, b_sh[Chunk-1:0]} - (Chunk+1)'(borrow);
    chunk_d    = chunk_full[Chunk-1:0];
    chunk_bout = chunk_full[Chunk];
    // Signs of A and B differ and the result sign differs from A.
    chunk_ovf  = (a_sh[Chunk-1] ^ b_sh[Chunk-1]) & (chunk_d[Chunk-1] ^ a_sh[Chunk-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    last_chunk = (cnt == LAST);
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      d_reg  <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_sh   <= A;
      b_sh   <= B;
      borrow <= Bin;
      cnt    <= '0;
    end else if (state_q == BUSY) begin
      a_sh   <= a_sh >> Chunk;
      b_sh   <= b_sh >> Chunk;
      borrow <= chunk_bout;
      d_reg  <= (d_reg >> Chunk) | (Ancho'(chunk_d) << (Ancho - Chunk));
      cnt    <= cnt + 1'b1;
      if (last_chunk) begin
        bout_q <= chunk_bout;
        ovf_q  <= chunk_ovf;
      end
    end
  end

  assign D        = d_reg;
  assign Bout     = bout_q;
  assign Overflow = ovf_q;

`ifdef RESTADOR_ZERO_FLAG_EN
  assign Zero = out_valid && (d_reg == '0);
`endif

endmodule

// File: tb/tb_restador_serial.sv
// Randomized self-checking bench for restador_serial (Ancho=8, Chunk=2).
// Zero flag is checked only when RESTADOR_ZERO_FLAG_EN is defined.
module tb_restador_serial;

  localparam int W = 8;
  localparam int C = 2;
  localparam int K = W / C;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A, B;
  logic         Bin;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] D;
  logic         Bout;
  logic         Overflow;
  logic         out_valid;
  logic         out_ready;
`ifdef RESTADOR_ZERO_FLAG_EN
  logic         Zero;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  restador_serial #(.Ancho(W), .Chunk(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .Bout      (Bout),
    .Overflow  (Overflow),
    .out_valid (out_valid),
`ifdef RESTADOR_ZERO_FLAG_EN
    .Zero      (Zero),
`endif
    .out_ready (out_ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: whole-word integer arithmetic, unsigned for borrow, signed for overflow.
  function automatic void refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                   output logic [W-1:0] d, output logic bo, output logic ov);
    int ud;
    int sd;
    ud = int'(a) - int'(b) - int'(bin);
    sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d  = W'(ud);
    bo = (ud < 0);
    ov = (sd < -(2 ** (W - 1))) || (sd > (2 ** (W - 1)) - 1);
  endfunction

  task automatic checkDone(input string tag, input logic [W-1:0] ed, input logic eb, input logic eo);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_in_ready"},  32'(in_ready),  32'd0);
    checkOutput({tag, "_D"},         32'(D),         32'(ed));
    checkOutput({tag, "_Bout"},      32'(Bout),      32'(eb));
    checkOutput({tag, "_Overflow"},  32'(Overflow),  32'(eo));
`ifdef RESTADOR_ZERO_FLAG_EN
    checkOutput({tag, "_Zero"},      32'(Zero),      32'(ed == '0));
`endif
  endtask

  // One full transaction; in_valid stays high through BUSY/DONE to prove it is ignored.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                               input int hold);
    logic [W-1:0] ed;
    logic         eb, eo;
    int           n;
    refModel(a, b, bin, ed, eb, eo);
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    out_ready = 1'($urandom);
    @(posedge clk); #1;
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    for (int i = 0; i < K; i++) begin
      checkOutput("busy_out_valid", 32'(out_valid), 32'd0);
      checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checkDone("done", ed, eb, eo);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkDone("hold", ed, eb, eo);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("handoff_out_valid", 32'(out_valid), 32'd0);
    checkOutput("handoff_in_ready", 32'(in_ready), 32'd1);
`ifdef RESTADOR_ZERO_FLAG_EN
    checkOutput("handoff_Zero", 32'(Zero), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; A = '0; B = '0; Bin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_D", 32'(D), 32'd0);
    checkOutput("reset_Bout", 32'(Bout), 32'd0);
    checkOutput("reset_Overflow", 32'(Overflow), 32'd0);
    rst = 1'b0;

    applyStimulus(8'h05, 8'h03, 1'b0, 3);
    applyStimulus(8'h00, 8'h01, 1'b0, 0);
    applyStimulus(8'h80, 8'h01, 1'b0, 1);
    applyStimulus(8'h7F, 8'hFF, 1'b0, 0);
    applyStimulus(8'h10, 8'h0F, 1'b1, 2);
    applyStimulus(8'h00, 8'hFF, 1'b1, 0);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 0);

    // Abort mid-operation: partial D is nonzero, reset must clear it at once.
    A = 8'hFF; B = 8'h00; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_D", 32'(D), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 2 * K; i++) begin
      @(posedge clk); #1;
      checkOutput("post_abort_out_valid", 32'(out_valid), 32'd0);
    end

    for (int t = 0; t < 40; t++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
